// File: rtl/dec_pkg.sv
// Shared types and decode helpers for the scanned decoder.
package dec_pkg;

   typedef enum logic {DIRECT = 1'b0, SCAN = 1'b1} mode_e;

   localparam int SEL_W_MAX = 8;
   localparam int NOUT_MAX  = 1 << SEL_W_MAX;

   // Output count for a given address width; callers bind this to a local NOUT.
   function automatic int nout(input int sel_w);
      return 1 << sel_w;
   endfunction

   // Full-width decode; callers truncate to their own NOUT.
   function automatic logic [NOUT_MAX-1:0] onehot_dec(input logic [SEL_W_MAX-1:0] addr,
                                                      input logic active_low);
      logic [NOUT_MAX-1:0] v;
      v = '0;
      v[addr] = 1'b1;
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/dec_slice.sv
// Combinational single-channel decoder; en_n or blank force the inactive level.
module dec_slice
   import dec_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter bit ACTIVE_LOW = 1'b1,
   localparam int NOUT      = nout(SEL_W)
) (
   input  logic [SEL_W-1:0] addr,
   input  logic             en_n,
   input  logic             blank,
   output logic [NOUT-1:0]  y
);

   always_comb begin
      y = {NOUT{ACTIVE_LOW}};
      if (!en_n && !blank) begin
         y = NOUT'(onehot_dec(SEL_W_MAX'(addr), ACTIVE_LOW));
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// CH registered SEL_W-to-2^SEL_W decoders with a prescaled scan mode and dead-time blanking.
module decoder_scan
   import dec_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter int CH         = 2,
   parameter int PRESCALE   = 4,
   parameter int DEAD       = 1,
   parameter bit ACTIVE_LOW = 1'b1,
   localparam int NOUT      = nout(SEL_W)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CH-1:0]         g,
   input  logic                  mode,
   input  logic [CH*SEL_W-1:0]   a,
   output logic [CH*NOUT-1:0]    y,
   output logic [SEL_W-1:0]      scan_idx,
   output logic                  wrap
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   mode_e              state, state_nxt;
   logic [PW-1:0]      pre, pre_nxt;
   logic [SEL_W-1:0]   idx_nxt;
   logic               wrap_nxt;
   logic               blank;
   logic [CH*NOUT-1:0] y_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= DIRECT;
         pre      <= '0;
         scan_idx <= '0;
         wrap     <= 1'b0;
         y        <= {(CH*NOUT){ACTIVE_LOW}};
      end else begin
         state    <= state_nxt;
         pre      <= pre_nxt;
         scan_idx <= idx_nxt;
         wrap     <= wrap_nxt;
         y        <= y_nxt;
      end
   end

   // Entering SCAN from DIRECT restarts at slot 0, so only SCAN->SCAN advances.
   always_comb begin
      state_nxt = mode ? SCAN : DIRECT;
      pre_nxt   = '0;
      idx_nxt   = '0;
      wrap_nxt  = 1'b0;
      case (state)
         SCAN: begin
            if (mode) begin
               if (pre == PMAX) begin
                  idx_nxt  = scan_idx + 1'b1;
                  wrap_nxt = (scan_idx == '1);
               end else begin
                  pre_nxt  = pre + 1'b1;
                  idx_nxt  = scan_idx;
               end
            end
         end
         default: ;
      endcase
   end

   if (DEAD == 0) begin : g_no_dead
      assign blank = 1'b0;
   end else begin : g_dead
      assign blank = mode && (pre_nxt < PW'(DEAD));
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      dec_slice #(
         .SEL_W      (SEL_W),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_slice (
         .addr  (mode ? idx_nxt : a[i*SEL_W +: SEL_W]),
         .en_n  (g[i]),
         .blank (blank),
         .y     (y_nxt[i*NOUT +: NOUT])
      );
   end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: default instance plus a SEL_W=3, CH=1, PRESCALE=1, DEAD=0, active-high instance.
module tb_decoder_scan;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] g;
   logic       mode;
   logic [3:0] a;
   logic [7:0] y;
   logic [1:0] scan_idx;
   logic       wrap;

   logic       g2;
   logic       mode2;
   logic [2:0] a2;
   logic [7:0] y2;
   logic [2:0] idx2;
   logic       wrap2;

   int errors = 0;
   int checks = 0;

   // Model: t counts cycles since the scan was entered.
   int t1 = 0, t2 = 0;
   bit run1 = 0, run2 = 0;
   logic [7:0] ey, ey2;
   logic [1:0] eidx;
   logic [2:0] eidx2;
   logic       ewrap, ewrap2;

   typedef struct {
      logic [1:0] g;
      logic [3:0] a;
      logic [7:0] y;
   } vec_t;
   vec_t vec[$];

   always #5 clk = ~clk;

   decoder_scan dut (
      .clk(clk), .rst_n(rst_n), .g(g), .mode(mode), .a(a),
      .y(y), .scan_idx(scan_idx), .wrap(wrap)
   );

   decoder_scan #(.SEL_W(3), .CH(1), .PRESCALE(1), .DEAD(0), .ACTIVE_LOW(1'b0)) dut8 (
      .clk(clk), .rst_n(rst_n), .g(g2), .mode(mode2), .a(a2),
      .y(y2), .scan_idx(idx2), .wrap(wrap2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // 74x139-style pair: PRESCALE=4, DEAD=1, 4 addresses.
   function automatic logic [7:0] ref_y(bit scan, int t, logic [1:0] gg, logic [3:0] aa);
      logic [7:0] r;
      int sel;
      r = '0;
      for (int ch = 0; ch < 2; ch++) begin
         sel = scan ? (t / 4) % 4 : int'(aa[ch*2 +: 2]);
         if ((scan && (t % 4) < 1) || gg[ch]) r[ch*4 +: 4] = 4'hF;
         else r[ch*4 +: 4] = 4'hF ^ (4'h1 << sel);
      end
      return r;
   endfunction

   function automatic logic [7:0] ref_y2(bit scan, int t, logic gg, logic [2:0] aa);
      if (gg) return 8'h00;
      if (scan) return 8'h01 << (t % 8);
      return 8'h01 << aa;
   endfunction

   task automatic set_reset_expect();
      run1 = 0; run2 = 0;
      ey = 8'hFF; eidx = 2'd0; ewrap = 1'b0;
      ey2 = 8'h00; eidx2 = 3'd0; ewrap2 = 1'b0;
   endtask

   task automatic check_model();
      chk("y", 32'(y), 32'(ey));
      chk("scan_idx", 32'(scan_idx), 32'(eidx));
      chk("wrap", 32'(wrap), 32'(ewrap));
      chk("y8", 32'(y2), 32'(ey2));
      chk("scan_idx8", 32'(idx2), 32'(eidx2));
      chk("wrap8", 32'(wrap2), 32'(ewrap2));
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         set_reset_expect();
      end else begin
         if (mode) begin t1 = run1 ? t1 + 1 : 0; run1 = 1; end else run1 = 0;
         if (mode2) begin t2 = run2 ? t2 + 1 : 0; run2 = 1; end else run2 = 0;
         ey     = ref_y(run1, t1, g, a);
         eidx   = run1 ? 2'((t1 / 4) % 4) : 2'd0;
         ewrap  = run1 && t1 > 0 && (t1 % 16) == 0;
         ey2    = ref_y2(run2, t2, g2, a2);
         eidx2  = run2 ? 3'(t2 % 8) : 3'd0;
         ewrap2 = run2 && t2 > 0 && (t2 % 8) == 0;
      end
      #1;
      check_model();
   endtask

   initial begin
      vec_t v;
      g = 2'b00; mode = 1'b0; a = 4'h0;
      g2 = 1'b0; mode2 = 1'b0; a2 = 3'd0;

      vec.push_back('{2'b00, 4'b0000, 8'hEE});
      vec.push_back('{2'b00, 4'b0110, 8'hDB});
      vec.push_back('{2'b01, 4'b1100, 8'h7F});
      vec.push_back('{2'b10, 4'b0001, 8'hFD});
      vec.push_back('{2'b11, 4'b1010, 8'hFF});
      for (int i = 0; i < 64; i++) begin
         v.g = 2'(i >> 4);
         v.a = 4'(i);
         v.y = ref_y(1'b0, 0, v.g, v.a);
         vec.push_back(v);
      end

      // Reset state, visible without any clock edge
      #2 rst_n = 1'b0;
      #2;
      set_reset_expect();
      check_model();
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_y", 32'(y), 32'h0000_00EE);

      foreach (vec[i]) begin
         g = vec[i].g;
         a = vec[i].a;
         step();
         chk("direct_tbl", 32'(y), 32'(vec[i].y));
      end

      // Full scan cycles on both instances
      g = 2'b00; g2 = 1'b0; mode = 1'b1; mode2 = 1'b1;
      repeat (40) step();

      // Leave scan mid-slot at index 2, then come back
      mode = 1'b0;
      step();
      mode = 1'b1;
      repeat (10) step();
      chk("idx_before_switch", 32'(scan_idx), 32'd2);
      mode = 1'b0; a = 4'b0110;
      step();
      chk("switch_idx", 32'(scan_idx), 32'd0);
      chk("switch_y", 32'(y), 32'h0000_00DB);
      mode = 1'b1;
      step();
      chk("reentry_blank", 32'(y), 32'h0000_00FF);
      step();
      chk("reentry_y", 32'(y), 32'h0000_00EE);
      repeat (6) step();

      // Asynchronous reset between edges while scanning
      #2 rst_n = 1'b0;
      #1;
      set_reset_expect();
      check_model();
      step();
      rst_n = 1'b1;
      repeat (20) step();

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 39) == 0) mode = ~mode;
         if ($urandom_range(0, 39) == 0) mode2 = ~mode2;
         if ($urandom_range(0, 5) == 0) g = 2'($urandom);
         if ($urandom_range(0, 7) == 0) g2 = 1'($urandom);
         a  = 4'($urandom);
         a2 = 3'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
